line_arbiter: RTL and testbench
===============================

Name: line_arbiter

Overview: Arbitrates cache-line requests from the instruction cache and the data cache onto the single cacheline port that feeds the burst adaptor to physical memory. It sits between the two caches and the cacheline adaptor in the memory subsystem under mp4. It grants one client at a time, holds the grant until the downstream response, and resolves ties by round-robin or by fixed data priority.

Parameters:
LINE_W, 256, cache line width in bits
ADDR_W, 32, line address width
DATA_PRIO, 0, 1 = data always wins ties; 0 = round-robin on ties

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_cache_address  in  ADDR_W  icache line address
instr_cache_read  in  1  icache line read request
instr_cache_write  in  1  icache line write request
instr_cache_to_pmem  in  LINE_W  icache writeback line
instr_pmem_to_cache  out  LINE_W  fill line to icache
instr_cache_resp  out  1  icache completion pulse
data_cache_address  in  ADDR_W  dcache line address
data_cache_read  in  1  dcache line read request
data_cache_write  in  1  dcache line write request
data_cache_to_pmem  in  LINE_W  dcache writeback line
data_pmem_to_cache  out  LINE_W  fill line to dcache
data_cache_resp  out  1  dcache completion pulse
cache_address  out  ADDR_W  address to adaptor
cache_read  out  1  read to adaptor
cache_write  out  1  write to adaptor
cache_to_pmem  out  LINE_W  write line to adaptor
pmem_to_cache  in  LINE_W  read line from adaptor
cache_resp  in  1  adaptor completion

Behaviour:
- States: IDLE, GNT_I, GNT_D, GAP. Registered state plus a last_grant flag (I/D).
- Reset (rst high at clk edge): state=IDLE, last_grant=I. During and after reset, all outputs are 0 (cache_read/write, both resps, cache_address, cache_to_pmem, both fill buses).
- A client request is req_x = x_cache_read | x_cache_write.
- IDLE: with no request, stay. With only one requester, go to that client's GNT state. With both requesting: if DATA_PRIO=1, go to GNT_D. Otherwise, go to the grant opposite last_grant. Because last_grant resets to I, data wins the first tie. Update last_grant on entry to a GNT state.
- GNT_x: cache_address, cache_read, cache_write and cache_to_pmem pass through combinationally from client x's live inputs. Client x must hold its inputs stable until its resp.
- GNT_x: pmem_to_cache drives x_pmem_to_cache. The other client's resp is 0 and its fill bus is 0.
- GNT_x on cache_resp=1: x_cache_resp=1 in the same cycle (combinational pass-through, exactly one cycle), then next state is GAP.
- GAP: exactly one cycle. All downstream request outputs are 0 and no grant is made. This absorbs the cache dropping its request the cycle after resp. Next state is IDLE.
- Latency: a request first seen in IDLE at edge N makes cache_read/write visible after edge N, in cycle N+1. Minimum occupancy per transaction is request cycle + adaptor latency + GAP.
- A client asserting both read and write in a grant is forwarded unmodified; the adaptor defines that behaviour and the arbiter does not check it.
- A request that drops while granted before resp is a client protocol violation. The arbiter stays in GNT_x and forwards 0s until cache_resp.
- Starvation: with DATA_PRIO=0, back-to-back contention alternates grants, so the maximum wait is one transaction.
- Reset mid-transaction: the FSM returns to IDLE, outputs drop immediately, and no resp is generated for the aborted transaction.

Test Plan:
- Single icache read, addr 0x0000_1040: cache_read=1 from cycle 1 → adaptor resp at cycle 5 with line 0xA5..A5. Required: instr_cache_resp=1 in cycle 5 only, instr_pmem_to_cache=0xA5..A5, data_cache_resp stays 0, GAP in cycle 6.
- Simultaneous icache read 0x100 and dcache write 0x200 in the same cycle, DATA_PRIO=0, just after reset → data is served first (cache_write=1, cache_address=0x200), then after GAP the icache is served (0x100).
- Continuous contention over 4 transactions, DATA_PRIO=0 → grant order D,I,D,I. With DATA_PRIO=1 → D,D,D,D while data keeps requesting.
- Cache holds its request for one cycle after resp → no duplicate downstream read is issued; cache_read=0 in the GAP cycle.
- rst asserted while in GNT_D before cache_resp → next cycle cache_read=cache_write=0, state IDLE, no data_cache_resp pulse. After release, a fresh icache request is granted normally.
- dcache writeback of line 0x1234..5678 to 0x8000_0000 → cache_to_pmem equals that line for the whole grant, and data_pmem_to_cache=0 throughout.

Source files
------------

// File: rtl/line_arbiter.sv
// -----------------------------------------------------------------------------
// line_arbiter
//
// Shares the single cache-line port of the burst adaptor between the
// instruction cache and the data cache. One client owns the port at a time;
// ownership lasts until the adaptor's completion. Every transaction is
// followed by a single dead cycle. That cycle lets the client lower its
// request before the arbiter looks at requests again.
//
// Tie-break when both caches request in the same idle cycle:
//   DATA_PRIO = 1 : the data cache always wins.
//   DATA_PRIO = 0 : the client that did not win the previous grant is chosen.
//                   The history starts at "instruction", so data wins the
//                   first tie after reset.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   instr_cache_*              icache side: address, read, write, writeback
//                              line in; fill line and completion pulse out
//   data_cache_*               dcache side, same shape as the icache side
//   cache_address/read/write   request to the adaptor
//   cache_to_pmem              writeback line to the adaptor
//   pmem_to_cache, cache_resp  fill line and completion from the adaptor
// -----------------------------------------------------------------------------
module line_arbiter #(
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int DATA_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] instr_cache_address,
    input  logic              instr_cache_read,
    input  logic              instr_cache_write,
    input  logic [LINE_W-1:0] instr_cache_to_pmem,
    output logic [LINE_W-1:0] instr_pmem_to_cache,
    output logic              instr_cache_resp,

    input  logic [ADDR_W-1:0] data_cache_address,
    input  logic              data_cache_read,
    input  logic              data_cache_write,
    input  logic [LINE_W-1:0] data_cache_to_pmem,
    output logic [LINE_W-1:0] data_pmem_to_cache,
    output logic              data_cache_resp,

    output logic [ADDR_W-1:0] cache_address,
    output logic              cache_read,
    output logic              cache_write,
    output logic [LINE_W-1:0] cache_to_pmem,
    input  logic [LINE_W-1:0] pmem_to_cache,
    input  logic              cache_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic LAST_I      = 1'b0;
    localparam logic LAST_D      = 1'b1;
    localparam logic DATA_PRIO_C = (DATA_PRIO != 0);

    state_t state_r;
    logic   last_grant_r;
    logic   req_i_s;
    logic   req_d_s;
    logic   tie_to_d_s;

    assign req_i_s = instr_cache_read | instr_cache_write;
    assign req_d_s = data_cache_read  | data_cache_write;

    // On a tie, data wins under fixed priority or when icache had the last grant.
    assign tie_to_d_s = DATA_PRIO_C | (last_grant_r == LAST_I);

    // Grant state machine and grant history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= LAST_I;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_d_s && (!req_i_s || tie_to_d_s)) begin
                        state_r      <= GNT_D;
                        last_grant_r <= LAST_D;
                    end else if (req_i_s) begin
                        state_r      <= GNT_I;
                        last_grant_r <= LAST_I;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                GNT_I: begin
                    if (cache_resp) begin
                        state_r <= GAP;
                    end else begin
                        state_r <= GNT_I;
                    end
                end
                GNT_D: begin
                    if (cache_resp) begin
                        state_r <= GAP;
                    end else begin
                        state_r <= GNT_D;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Route the granted client onto the adaptor port.
    // rst also forces every output low, so a transaction that reset
    // interrupts can never emit a completion pulse.
    always_comb begin
        cache_address       = {ADDR_W{1'b0}};
        cache_read          = 1'b0;
        cache_write         = 1'b0;
        cache_to_pmem       = {LINE_W{1'b0}};
        instr_pmem_to_cache = {LINE_W{1'b0}};
        instr_cache_resp    = 1'b0;
        data_pmem_to_cache  = {LINE_W{1'b0}};
        data_cache_resp     = 1'b0;
        if (rst) begin
            cache_read = 1'b0;
        end else begin
            case (state_r)
                GNT_I: begin
                    cache_address       = instr_cache_address;
                    cache_read          = instr_cache_read;
                    cache_write         = instr_cache_write;
                    cache_to_pmem       = instr_cache_to_pmem;
                    instr_pmem_to_cache = pmem_to_cache;
                    instr_cache_resp    = cache_resp;
                end
                GNT_D: begin
                    cache_address       = data_cache_address;
                    cache_read          = data_cache_read;
                    cache_write         = data_cache_write;
                    cache_to_pmem       = data_cache_to_pmem;
                    data_pmem_to_cache  = pmem_to_cache;
                    data_cache_resp     = cache_resp;
                end
                default: begin
                    cache_read = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_arbiter
//
// Two arbiters run side by side: dut0 uses round-robin tie-break and dut1
// uses fixed data priority. Each DUT has its own randomized icache and
// dcache clients and its own randomized adaptor. The clients and the
// adaptors react to a transaction-level reference model, not to the DUT.
// The model tracks which client owns the port, the dead cycle that follows
// each completion, and which client was served last. Every cycle, all DUT
// outputs are compared against what the model says the port should show.
// -----------------------------------------------------------------------------
module tb_line_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int NCYC   = 2400;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Client ports, indexed [dut][client]. Client 0 is the icache and client 1 is the dcache.
    logic [ADDR_W-1:0] cl_addr  [2][2];
    logic              cl_rd    [2][2];
    logic              cl_wr    [2][2];
    logic [LINE_W-1:0] cl_wline [2][2];
    logic [LINE_W-1:0] cl_fill  [2][2];
    logic              cl_resp  [2][2];

    // Adaptor side, indexed [dut]
    logic [ADDR_W-1:0] c_addr  [2];
    logic              c_rd    [2];
    logic              c_wr    [2];
    logic [LINE_W-1:0] c_wline [2];
    logic [LINE_W-1:0] p_line  [2];
    logic              c_resp  [2];

    line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DATA_PRIO(0)) dut0 (
        .clk(clk), .rst(rst),
        .instr_cache_address(cl_addr[0][0]), .instr_cache_read(cl_rd[0][0]),
        .instr_cache_write(cl_wr[0][0]), .instr_cache_to_pmem(cl_wline[0][0]),
        .instr_pmem_to_cache(cl_fill[0][0]), .instr_cache_resp(cl_resp[0][0]),
        .data_cache_address(cl_addr[0][1]), .data_cache_read(cl_rd[0][1]),
        .data_cache_write(cl_wr[0][1]), .data_cache_to_pmem(cl_wline[0][1]),
        .data_pmem_to_cache(cl_fill[0][1]), .data_cache_resp(cl_resp[0][1]),
        .cache_address(c_addr[0]), .cache_read(c_rd[0]), .cache_write(c_wr[0]),
        .cache_to_pmem(c_wline[0]), .pmem_to_cache(p_line[0]), .cache_resp(c_resp[0])
    );

    line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DATA_PRIO(1)) dut1 (
        .clk(clk), .rst(rst),
        .instr_cache_address(cl_addr[1][0]), .instr_cache_read(cl_rd[1][0]),
        .instr_cache_write(cl_wr[1][0]), .instr_cache_to_pmem(cl_wline[1][0]),
        .instr_pmem_to_cache(cl_fill[1][0]), .instr_cache_resp(cl_resp[1][0]),
        .data_cache_address(cl_addr[1][1]), .data_cache_read(cl_rd[1][1]),
        .data_cache_write(cl_wr[1][1]), .data_cache_to_pmem(cl_wline[1][1]),
        .data_pmem_to_cache(cl_fill[1][1]), .data_cache_resp(cl_resp[1][1]),
        .cache_address(c_addr[1]), .cache_read(c_rd[1]), .cache_write(c_wr[1]),
        .cache_to_pmem(c_wline[1]), .pmem_to_cache(p_line[1]), .cache_resp(c_resp[1])
    );

    // Reference model state, per DUT. owner: 0 = nobody, 1 = icache, 2 = dcache.
    int owner  [2];
    bit in_gap [2];
    bit last_d [2];
    int a_left [2];
    // Client behaviour: busy while waiting for resp; linger holds the request one extra cycle.
    bit busy   [2][2];
    bit linger [2][2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int served   [2][2];

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs,
                            input logic [LINE_W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare every output of DUT k against the model's view of the port.
    task automatic check_dut(input int k);
        logic [ADDR_W-1:0] e_addr;
        logic              e_rd;
        logic              e_wr;
        logic [LINE_W-1:0] e_wl;
        logic [LINE_W-1:0] e_fill [2];
        logic              e_resp [2];
        int                o;
        e_addr    = '0;
        e_rd      = 1'b0;
        e_wr      = 1'b0;
        e_wl      = '0;
        e_fill[0] = '0;
        e_fill[1] = '0;
        e_resp[0] = 1'b0;
        e_resp[1] = 1'b0;
        o = rst ? 0 : owner[k];
        if (o != 0) begin
            e_addr      = cl_addr[k][o-1];
            e_rd        = cl_rd[k][o-1];
            e_wr        = cl_wr[k][o-1];
            e_wl        = cl_wline[k][o-1];
            e_fill[o-1] = p_line[k];
            e_resp[o-1] = c_resp[k];
        end
        check_eq($sformatf("dut%0d cache_address", k), LINE_W'(c_addr[k]), LINE_W'(e_addr));
        check_eq($sformatf("dut%0d cache_read", k), LINE_W'(c_rd[k]), LINE_W'(e_rd));
        check_eq($sformatf("dut%0d cache_write", k), LINE_W'(c_wr[k]), LINE_W'(e_wr));
        check_eq($sformatf("dut%0d cache_to_pmem", k), c_wline[k], e_wl);
        check_eq($sformatf("dut%0d instr_fill", k), cl_fill[k][0], e_fill[0]);
        check_eq($sformatf("dut%0d data_fill", k), cl_fill[k][1], e_fill[1]);
        check_eq($sformatf("dut%0d instr_resp", k), LINE_W'(cl_resp[k][0]), LINE_W'(e_resp[0]));
        check_eq($sformatf("dut%0d data_resp", k), LINE_W'(cl_resp[k][1]), LINE_W'(e_resp[1]));
    endtask

    // Advance DUT k's model across a clock edge, then choose the inputs for the next cycle.
    task automatic step_dut(input int k, input logic rst_new, input int pct);
        int   own_old;
        logic rq      [2];
        logic resp_ev [2];
        logic pick_d;
        own_old = owner[k];
        for (int c = 0; c < 2; c++) begin
            rq[c]      = cl_rd[k][c] | cl_wr[k][c];
            resp_ev[c] = !rst && (own_old == c + 1) && c_resp[k];
        end

        if (rst) begin
            owner[k]  = 0;
            in_gap[k] = 1'b0;
            last_d[k] = 1'b0;
        end else if (in_gap[k]) begin
            in_gap[k] = 1'b0;
        end else if (own_old != 0) begin
            if (c_resp[k]) begin
                served[k][own_old-1]++;
                owner[k]  = 0;
                in_gap[k] = 1'b1;
            end
        end else if (rq[0] || rq[1]) begin
            // Data is chosen if it is the only requester. On a tie, data is chosen
            // under fixed priority or if the icache was served last.
            pick_d    = rq[1] && (!rq[0] || (k == 1) || !last_d[k]);
            owner[k]  = pick_d ? 2 : 1;
            last_d[k] = pick_d;
        end

        for (int c = 0; c < 2; c++) begin
            if (rst_new) begin
                busy[k][c]     = 1'b0;
                linger[k][c]   = 1'b0;
                cl_rd[k][c]    = 1'b0;
                cl_wr[k][c]    = 1'b0;
                cl_addr[k][c]  = '0;
                cl_wline[k][c] = '0;
            end else if (resp_ev[c]) begin
                busy[k][c]   = 1'b0;
                linger[k][c] = ($urandom_range(0, 1) == 1);
                if (!linger[k][c]) begin
                    cl_rd[k][c] = 1'b0;
                    cl_wr[k][c] = 1'b0;
                end
            end else if (linger[k][c]) begin
                linger[k][c] = 1'b0;
                cl_rd[k][c]  = 1'b0;
                cl_wr[k][c]  = 1'b0;
            end else if (!busy[k][c] && (int'($urandom_range(0, 99)) < pct)) begin
                busy[k][c]     = 1'b1;
                cl_wr[k][c]    = ($urandom_range(0, 1) == 1);
                cl_rd[k][c]    = !cl_wr[k][c];
                cl_addr[k][c]  = $urandom & 32'hFFFF_FFE0;
                cl_wline[k][c] = {8{$urandom}};
            end
        end

        // The adaptor answers 0..3 cycles after the first cycle of a grant.
        if (rst_new) begin
            c_resp[k] = 1'b0;
        end else if (owner[k] != 0) begin
            if (own_old == 0) begin
                a_left[k] = int'($urandom_range(0, 3));
            end else begin
                a_left[k] = a_left[k] - 1;
            end
            c_resp[k] = (a_left[k] == 0);
        end else begin
            c_resp[k] = 1'b0;
        end
        p_line[k] = {8{$urandom}};
    endtask

    initial begin
        logic rst_new;
        int   pct;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            owner[k]  = 0;
            in_gap[k] = 1'b0;
            last_d[k] = 1'b0;
            a_left[k] = 0;
            c_resp[k] = 1'b0;
            p_line[k] = '0;
            for (int c = 0; c < 2; c++) begin
                busy[k][c]     = 1'b0;
                linger[k][c]   = 1'b0;
                served[k][c]   = 0;
                cl_rd[k][c]    = 1'b0;
                cl_wr[k][c]    = 1'b0;
                cl_addr[k][c]  = '0;
                cl_wline[k][c] = '0;
            end
        end

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            // Phases: sparse traffic, then continuous contention, then mixed traffic.
            if (cyc < 900) begin
                pct = 30;
            end else if (cyc < 1600) begin
                pct = 100;
            end else begin
                pct = 60;
            end
            rst_new = (cyc < 3) || ($urandom_range(0, 249) == 0);
            for (int k = 0; k < 2; k++) begin
                step_dut(k, rst_new, pct);
            end
            rst = rst_new;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check_dut(k);
            end
        end

        // Round-robin must have served both clients. That includes the long
        // contention phase, where alternation is the only thing that lets the icache in.
        check_eq("dut0 icache served", LINE_W'(served[0][0] > 20), LINE_W'(1'b1));
        check_eq("dut0 dcache served", LINE_W'(served[0][1] > 20), LINE_W'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
